// File: rtl/pe_alu_exec.sv
// rtl/pe_alu_exec.sv - single-issue ALU with registered result and optional shift-add multiplier
// Optional multiplier enabled by defining PE_ALU_MUL_EN; otherwise op_sel=5 is treated as illegal.
module pe_alu_exec #(
  parameter int WIDTH        = 32,
  parameter int MUL_CYC_BITS = 5
) (
  input  logic             UserCLK,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             illegal_op,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
`ifdef PE_ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd5;
`endif

  if ((1 << MUL_CYC_BITS) != WIDTH || WIDTH < 8 || WIDTH > 32 || (WIDTH % 8) != 0) begin : g_bad_cfg
    $error("pe_alu_exec: unsupported WIDTH/MUL_CYC_BITS combination");
  end

  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state;

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_ill;

  // The result register may drain on the same edge a new request lands.
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    case (op_sel)
      OP_ADD: begin alu_y = add_sum[WIDTH-1:0]; alu_c = add_sum[WIDTH]; end
      OP_SUB: begin alu_y = sub_sum[WIDTH-1:0]; alu_c = sub_sum[WIDTH]; end
      OP_AND: alu_y = A & B;
      OP_OR:  alu_y = A | B;
      OP_XOR: alu_y = A ^ B;
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef PE_ALU_MUL_EN
  logic [MUL_CYC_BITS-1:0] mul_cnt;
  logic [WIDTH-1:0]        mul_acc;
  logic [WIDTH-1:0]        mul_mcand;
  logic [WIDTH-1:0]        mul_mplier;
  logic [WIDTH-1:0]        mul_acc_next;

  assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      Y          <= '0;
      carry      <= 1'b0;
      illegal_op <= 1'b0;
      out_valid  <= 1'b0;
`ifdef PE_ALU_MUL_EN
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef PE_ALU_MUL_EN
            if (op_sel == OP_MUL) begin
              state      <= MUL_BUSY;
              out_valid  <= 1'b0;
              mul_cnt    <= '0;
              mul_acc    <= '0;
              mul_mcand  <= A;
              mul_mplier <= B;
            end else begin
`else
            begin
`endif
              Y          <= alu_y;
              carry      <= alu_c;
              illegal_op <= alu_ill;
              out_valid  <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
`ifdef PE_ALU_MUL_EN
        // One multiplier bit per cycle; low WIDTH bits are sign-agnostic.
        MUL_BUSY: begin
          mul_acc    <= mul_acc_next;
          mul_mcand  <= {mul_mcand[WIDTH-2:0], 1'b0};
          mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
          mul_cnt    <= mul_cnt + 1'b1;
          if (mul_cnt == {MUL_CYC_BITS{1'b1}}) begin
            Y          <= mul_acc_next;
            carry      <= 1'b0;
            illegal_op <= 1'b0;
            out_valid  <= 1'b1;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
